// File: rtl/perturb_gen.sv
// perturb_gen: a bank of independent XNOR Galois-free (Fibonacci) LFSR channels
// producing either raw uniform bits or a bipolar +/-amp dither per channel.
// Every channel shifts on the same step strobe. Seeds come from a common base
// plus a per-channel stride. The all-ones XNOR lock-up state is never loaded.
module perturb_gen #(
   parameter int                   CHANNELS    = 4,
   parameter int                   REG_WIDTH   = 31,
   parameter int                   OUT_WIDTH   = 11,
   parameter logic [31:0]          SEED        = 32'd24218329,
   parameter logic [31:0]          SEED_STRIDE = 32'h9E3779B9,
   parameter logic [REG_WIDTH-1:0] TAP_MASK    = REG_WIDTH'(32'h9),
   parameter int                   CNT_WIDTH   = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en,
   input  logic                            mode,
   input  logic [OUT_WIDTH-1:0]            amp,
   input  logic                            seed_load,
   input  logic [REG_WIDTH-1:0]            seed_in,
   output logic [CHANNELS*OUT_WIDTH-1:0]   random,
   output logic                            valid,
   output logic                            lockup,
   output logic [CNT_WIDTH-1:0]            step_cnt
);

   typedef logic [CHANNELS-1:0][REG_WIDTH-1:0] lfsr_vec_t;

   // Illegal parameter combinations stop elaboration.
   if (OUT_WIDTH > REG_WIDTH || CHANNELS < 1 || TAP_MASK == '0) begin : g_param_err
      $error("perturb_gen: illegal parameters (OUT_WIDTH > REG_WIDTH, CHANNELS < 1 or TAP_MASK == 0)");
   end

   // Raw seed of one channel: base + c*stride, truncated to the register width.
   function automatic logic [REG_WIDTH-1:0] raw_seed(input logic [63:0] base, input int c);
      logic [63:0] s;
      s = base + 64'(c) * 64'(SEED_STRIDE);
      return s[REG_WIDTH-1:0];
   endfunction

   // Seeds for all channels, with the all-ones lock-up state nudged off by one bit.
   function automatic lfsr_vec_t seeds_from(input logic [63:0] base);
      lfsr_vec_t                r;
      logic [REG_WIDTH-1:0]     s;
      r = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         s = raw_seed(base, c);
         r[c] = (s == '1) ? (s ^ REG_WIDTH'(1)) : s;
      end
      return r;
   endfunction

   // True when any channel's raw seed would have been the lock-up state.
   function automatic logic any_lock(input logic [63:0] base);
      logic hit;
      hit = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (raw_seed(base, c) == '1) hit = 1'b1;
      end
      return hit;
   endfunction

   localparam lfsr_vec_t RST_LFSR = seeds_from(64'(SEED));
   localparam logic      RST_LOCK = any_lock(64'(SEED));

   lfsr_vec_t                    lfsr_q, lfsr_d;
   logic [CHANNELS*OUT_WIDTH-1:0] random_q, random_d;
   logic                         valid_q, valid_d;
   logic                         lockup_q, lockup_d;
   logic [CNT_WIDTH-1:0]         step_cnt_q, step_cnt_d;
   logic [OUT_WIDTH-1:0]         neg_amp;

   // Two's-complement negation wraps naturally at OUT_WIDTH bits; -0 stays 0.
   assign neg_amp = (~amp) + OUT_WIDTH'(1);

   // Next-state: seed_load wins over en; en shifts every channel and refreshes the output.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      lfsr_d     = lfsr_q;
      random_d   = random_q;
      valid_d    = 1'b0;
      lockup_d   = lockup_q;
      step_cnt_d = step_cnt_q;
      if (seed_load) begin
         lfsr_d     = seeds_from(64'(seed_in));
         lockup_d   = any_lock(64'(seed_in));
         step_cnt_d = '0;
      end else if (en) begin
         valid_d    = 1'b1;
         step_cnt_d = step_cnt_q + CNT_WIDTH'(1);
         for (int c = 0; c < CHANNELS; c++) begin
            lfsr_d[c] = {~^(lfsr_q[c] & TAP_MASK), lfsr_q[c][REG_WIDTH-1:1]};
            if (mode) begin
               random_d[c*OUT_WIDTH +: OUT_WIDTH] = lfsr_d[c][0] ? amp : neg_amp;
            end else begin
               random_d[c*OUT_WIDTH +: OUT_WIDTH] = lfsr_d[c][OUT_WIDTH-1:0];
            end
         end
      end
   end

   // State registers; reset returns the LFSRs to the SEED-derived values without a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q     <= RST_LFSR;
         random_q   <= '0;
         valid_q    <= 1'b0;
         lockup_q   <= RST_LOCK;
         step_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         lfsr_q     <= lfsr_d;
         random_q   <= random_d;
         valid_q    <= valid_d;
         lockup_q   <= lockup_d;
         step_cnt_q <= step_cnt_d;
      end
   end

   assign random   = random_q;
   assign valid    = valid_q;
   assign lockup   = lockup_q;
   assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_perturb_gen.sv
// Directed self-checking bench for perturb_gen: default instance, a one-channel
// 4-bit-counter instance, and a one-channel instance whose SEED is the lock-up state.
module tb_perturb_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        en, mode, seed_load;
   logic [10:0] amp;
   logic [30:0] seed_in;
   logic [43:0] random;
   logic        valid, lockup;
   logic [15:0] step_cnt;

   logic        en_b, seed_load_b;
   logic [30:0] seed_in_b;
   logic [10:0] random_b;
   logic        valid_b, lockup_b;
   logic [3:0]  step_cnt_b;

   logic [10:0] random_c;
   logic        valid_c, lockup_c;
   logic [15:0] step_cnt_c;

   int checks = 0;
   int errors = 0;

   logic [30:0] m [4];
   logic [43:0] exp_vec;

   always #5 clk = ~clk;

   perturb_gen dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .amp(amp),
      .seed_load(seed_load), .seed_in(seed_in),
      .random(random), .valid(valid), .lockup(lockup), .step_cnt(step_cnt)
   );

   perturb_gen #(.CHANNELS(1), .CNT_WIDTH(4)) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .mode(mode), .amp(amp),
      .seed_load(seed_load_b), .seed_in(seed_in_b),
      .random(random_b), .valid(valid_b), .lockup(lockup_b), .step_cnt(step_cnt_b)
   );

   perturb_gen #(.CHANNELS(1), .SEED(32'h7FFFFFFF)) dut_c (
      .clk(clk), .rst(rst), .en(1'b0), .mode(1'b0), .amp(11'd0),
      .seed_load(1'b0), .seed_in(31'd0),
      .random(random_c), .valid(valid_c), .lockup(lockup_c), .step_cnt(step_cnt_c)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [30:0] m_step(input logic [30:0] v);
      return {(v[3] == v[0]), v[30:1]};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b0; mode = 1'b0; amp = '0; seed_load = 1'b0; seed_in = '0;
      en_b = 1'b0; seed_load_b = 1'b0; seed_in_b = '0;

      // Reset state, observed before any clock edge.
      #1;
      check("rst_random",   random,          0);
      check("rst_valid",    valid,           0);
      check("rst_step_cnt", step_cnt,        0);
      check("rst_lockup",   lockup,          0);
      check("rst_lfsr0",    dut.lfsr_q[0],   31'h01718AD9);
      check("rst_lfsr1",    dut.lfsr_q[1],   31'h1FA90492);
      check("rst_c_lfsr",   dut_c.lfsr_q[0], 31'h7FFFFFFE);
      check("rst_c_lockup", lockup_c,        1);
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("idle_valid", valid, 0);

      // Three mode-0 steps from the SEED-derived channel 0 state.
      en = 1'b1;
      tick();
      check("s1_ch0",   random[10:0], 11'h56C);
      check("s1_valid", valid,        1);
      check("s1_cnt",   step_cnt,     1);
      tick();
      check("s2_ch0",   random[10:0], 11'h2B6);
      check("s2_valid", valid,        1);
      check("s2_cnt",   step_cnt,     2);
      tick();
      check("s3_ch0",   random[10:0], 11'h15B);
      check("s3_valid", valid,        1);
      check("s3_cnt",   step_cnt,     3);

      // seed_load together with en: load wins, no shift, valid drops, counter clears.
      seed_load = 1'b1; seed_in = 31'd5;
      tick();
      check("ld_lfsr0", dut.lfsr_q[0], 31'd5);
      check("ld_lfsr1", dut.lfsr_q[1], 31'h1E3779BE);
      check("ld_valid", valid,         0);
      check("ld_cnt",   step_cnt,      0);
      check("ld_hold",  random[10:0],  11'h15B);
      seed_load = 1'b0;
      tick();
      check("ld_s1_ch0",   random[10:0],  11'd2);
      check("ld_s1_ch1",   random[21:11], 11'h4DF);
      check("ld_s1_valid", valid,         1);
      check("ld_s1_cnt",   step_cnt,      1);

      // Bipolar mode, amp=100, eight steps tracked by a reference model.
      en = 1'b0; seed_load = 1'b1; seed_in = 31'h00ABCDEF; mode = 1'b1; amp = 11'd100;
      tick();
      for (int c = 0; c < 4; c++) m[c] = 31'(32'h00ABCDEF + 32'(c) * 32'h9E3779B9);
      check("bp_lockup", lockup, 0);
      seed_load = 1'b0; en = 1'b1;
      for (int s = 0; s < 8; s++) begin
         tick();
         for (int c = 0; c < 4; c++) begin
            m[c] = m_step(m[c]);
            exp_vec[c*11 +: 11] = m[c][0] ? 11'd100 : 11'd1948;
         end
         check($sformatf("bp_step%0d", s), random, exp_vec);
      end

      // mode/amp changes while idle leave random untouched.
      en = 1'b0; mode = 1'b0; amp = 11'd7;
      tick();
      check("idle_hold",  random, exp_vec);
      check("idle_valid2", valid, 0);

      // amp=0 gives zero in every field regardless of sign.
      en = 1'b1; mode = 1'b1; amp = 11'd0;
      tick();
      check("amp0", random, 0);

      // Mode-0 step: every channel follows the model independently.
      mode = 1'b0;
      tick();
      for (int c = 0; c < 4; c++) begin
         m[c] = m_step(m[c]);
         m[c] = m_step(m[c]);
         exp_vec[c*11 +: 11] = m[c][10:0];
      end
      check("m0_all", random, exp_vec);
      check("m0_valid", valid, 1);

      // Asynchronous reset between edges while valid is high.
      en = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("mid_random", random,        0);
      check("mid_valid",  valid,         0);
      check("mid_cnt",    step_cnt,      0);
      check("mid_lfsr0",  dut.lfsr_q[0], 31'h01718AD9);
      #2 rst = 1'b0;
      tick();

      // Lock-up seed substitution and its sticky flag on the one-channel instance.
      seed_load_b = 1'b1; seed_in_b = 31'h7FFFFFFF;
      tick();
      check("lk_lfsr",   dut_b.lfsr_q[0], 31'h7FFFFFFE);
      check("lk_lockup", lockup_b,        1);
      seed_load_b = 1'b0; en_b = 1'b1;
      tick();
      check("lk_sticky", lockup_b, 1);
      check("lk_random", random_b, 11'h7FF);
      en_b = 1'b0; seed_load_b = 1'b1; seed_in_b = 31'd1;
      tick();
      check("lk_clear",  lockup_b,        0);
      check("lk_lfsr1",  dut_b.lfsr_q[0], 31'd1);
      check("lk_cnt",    step_cnt_b,      0);

      // 4-bit step counter wraps after 16 shifts.
      seed_load_b = 1'b0; en_b = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      check("wrap_15", step_cnt_b, 15);
      tick();
      check("wrap_16", step_cnt_b, 0);
      tick();
      check("wrap_17", step_cnt_b, 1);
      en_b = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
